// File: rtl/br_flow_demux_stage.sv
// br_flow_demux_stage: head storage for the demux, single entry or main+skid pair.
module br_flow_demux_stage #(
  parameter int Width = 1,
  parameter int RegisterPushReady = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             push_ready,
  input  logic             push_valid,
  input  logic [Width-1:0] push_data,
  output logic             head_valid,
  input  logic             head_ready,
  output logic [Width-1:0] head_data
);
  logic vld;
  logic [Width-1:0] data;
  assign head_valid = vld;
  assign head_data = data;
  if (RegisterPushReady == 0) begin : g_single
    logic push_acc;
    assign push_ready = rst_n & (!vld | head_ready);
    assign push_acc = push_valid & push_ready;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld <= 1'b0;
      else vld <= push_acc | (vld & !head_ready);
    end
    always_ff @(posedge clk) begin
      if (push_acc) data <= push_data;
    end
  end else begin : g_skid
    logic skid_vld, skid_vld_n, vld_n, rdy_q, push_acc, pop_acc;
    logic [Width-1:0] skid_data;
    assign push_ready = rdy_q;
    assign push_acc = push_valid & rdy_q;
    assign pop_acc = vld & head_ready;
    // rdy_q looks at the next skid state so push_ready stays a pure flop
    always_comb begin
      vld_n = (vld & !head_ready) | skid_vld | push_acc;
      skid_vld_n = skid_vld ? !pop_acc : (push_acc & vld & !head_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        skid_vld <= 1'b0;
        rdy_q <= 1'b0;
      end else begin
        vld <= vld_n;
        skid_vld <= skid_vld_n;
        rdy_q <= !skid_vld_n;
      end
    end
    always_ff @(posedge clk) begin
      if ((!vld | pop_acc) & (skid_vld | push_acc)) data <= skid_vld ? skid_data : push_data;
      if (!skid_vld & push_acc) skid_data <= push_data;
    end
  end
endmodule

// File: rtl/br_flow_demux_select_stable.sv
// br_flow_demux_select_stable: steer one ready/valid flow to N flows with flop-stable pop outputs.
module br_flow_demux_select_stable #(
  parameter int NumFlows = 2,
  parameter int Width = 1,
  parameter int RegisterPushReady = 0,
  parameter int EnableAssertPushValidStability = 1,
  parameter int EnableAssertPushDataStability = EnableAssertPushValidStability,
  parameter int EnableAssertFinalNotValid = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic                                 push_ready,
  input  logic                                 push_valid,
  input  logic [Width-1:0]                     push_data,
  input  logic [$clog2(NumFlows)-1:0]          push_select,
  input  logic [NumFlows-1:0]                  pop_ready,
  output logic [NumFlows-1:0]                  pop_valid,
  output logic [NumFlows-1:0][Width-1:0]       pop_data
);
  localparam int SelWidth = $clog2(NumFlows);
  logic sel_ok, head_valid, head_ready;
  logic [SelWidth+Width-1:0] head;
  logic [SelWidth-1:0] head_sel;
  // out-of-range selects are accepted but never stored, so they vanish
  assign sel_ok = int'(push_select) < NumFlows;
  br_flow_demux_stage #(
    .Width(SelWidth + Width),
    .RegisterPushReady(RegisterPushReady)
  ) stage (
    .clk(clk),
    .rst_n(rst_n),
    .push_ready(push_ready),
    .push_valid(push_valid & sel_ok),
    .push_data({push_select, push_data}),
    .head_valid(head_valid),
    .head_ready(head_ready),
    .head_data(head)
  );
  assign head_sel = head[Width +: SelWidth];
  assign head_ready = pop_ready[head_sel];
  assign pop_valid = {NumFlows{head_valid}} & (NumFlows'(1) << head_sel);
  assign pop_data = {NumFlows{head[Width-1:0]}};
  if (EnableAssertPushValidStability != 0) begin : g_push_valid_stable
    assert property (@(posedge clk) disable iff (!rst_n) push_valid && !push_ready |=> push_valid);
  end
  if (EnableAssertPushDataStability != 0) begin : g_push_data_stable
    assert property (@(posedge clk) disable iff (!rst_n)
      push_valid && !push_ready |=> $stable(push_data) && $stable(push_select));
  end
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pop_valid));
  assert property (@(posedge clk) disable iff (!rst_n)
    |(pop_valid & ~pop_ready) |=> $stable(pop_valid) && $stable(pop_data));
  if (EnableAssertFinalNotValid != 0) begin : g_final_not_valid
    final assert (pop_valid == '0);
  end
endmodule

// File: tb/tb_br_flow_demux_select_stable.sv
// tb_br_flow_demux_select_stable: both ready modes against a FIFO-queue reference model.
module tb_br_flow_demux_select_stable;
  logic clk, rst_n;
  logic push_ready [2];
  logic push_valid [2];
  logic [7:0] push_data [2];
  logic [1:0] push_select [2];
  logic [3:0] pop_ready [2];
  logic [3:0] pop_valid [2];
  logic [3:0][7:0] pop_data [2];
  int checks = 0, passed = 0, pops = 0;
  logic [9:0] q[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    br_flow_demux_select_stable #(.NumFlows(4), .Width(8), .RegisterPushReady(g)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .push_ready(push_ready[g]),
      .push_valid(push_valid[g]),
      .push_data(push_data[g]),
      .push_select(push_select[g]),
      .pop_ready(pop_ready[g]),
      .pop_valid(pop_valid[g]),
      .pop_data(pop_data[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle against the model: beats leave in push order, capacity 1 or 2
  task automatic step(input int m, input logic pv, input logic [7:0] d, input logic [1:0] s,
                      input logic [3:0] pr, output logic acc);
    logic [3:0] exp_pv;
    logic exp_pr;
    @(negedge clk);
    push_valid[m] = pv; push_data[m] = d; push_select[m] = s; pop_ready[m] = pr;
    #1;
    exp_pv = (q.size() != 0) ? (4'b0001 << q[0][9:8]) : 4'b0000;
    exp_pr = (m == 1) ? (q.size() < 2) : (q.size() == 0 || pr[q[0][9:8]]);
    checks++;
    if (pop_valid[m] !== exp_pv) $display("FAIL step_pop_valid m=%0d: got %b expected %b", m, pop_valid[m], exp_pv);
    else passed++;
    checks++;
    if (push_ready[m] !== exp_pr) $display("FAIL step_push_ready m=%0d: got %b expected %b", m, push_ready[m], exp_pr);
    else passed++;
    if (q.size() != 0) begin
      checks++;
      if (pop_data[m][q[0][9:8]] !== q[0][7:0])
        $display("FAIL step_pop_data m=%0d: got %h expected %h", m, pop_data[m][q[0][9:8]], q[0][7:0]);
      else passed++;
    end
    acc = pv & exp_pr;
    if (q.size() != 0 && pr[q[0][9:8]]) begin
      void'(q.pop_front());
      pops++;
    end
    if (acc) q.push_back({s, d});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (pop_valid[m] !== 4'b0 || push_ready[m] !== 1'b0)
          $display("FAIL reset_hold m=%0d: got pv=%b pr=%b expected pv=0000 pr=0", m, pop_valid[m], push_ready[m]);
        else passed++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (pop_valid[m] !== 4'b0 || push_ready[m] !== 1'b1)
          $display("FAIL reset_idle m=%0d: got pv=%b pr=%b expected pv=0000 pr=1", m, pop_valid[m], push_ready[m]);
        else passed++;
      end
    end
  endtask

  task automatic test_routing(input int m);
    @(negedge clk);
    push_valid[m] = 1'b1; push_data[m] = 8'hA5; push_select[m] = 2'd2; pop_ready[m] = 4'hF;
    @(negedge clk);
    push_valid[m] = 1'b0;
    #1;
    checks++;
    if (pop_valid[m] !== 4'b0100 || pop_data[m][2] !== 8'hA5)
      $display("FAIL routing m=%0d: got pv=%b d=%h expected pv=0100 d=a5", m, pop_valid[m], pop_data[m][2]);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if (pop_valid[m] !== 4'b0) $display("FAIL routing_clear m=%0d: got %b expected 0000", m, pop_valid[m]);
    else passed++;
  endtask

  task automatic test_backpressure(input int m);
    @(negedge clk);
    push_valid[m] = 1'b1; push_data[m] = 8'h11; push_select[m] = 2'd1; pop_ready[m] = 4'h0;
    @(negedge clk);
    push_data[m] = 8'h22; push_select[m] = 2'd3;
    #1;
    checks++;
    if (push_ready[m] !== (m == 1)) $display("FAIL bp_second_ready m=%0d: got %b expected %b", m, push_ready[m], m == 1);
    else passed++;
    if (m == 1) begin
      @(negedge clk);
      push_valid[m] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (pop_valid[m] !== 4'b0010 || pop_data[m][1] !== 8'h11 || push_ready[m] !== 1'b0)
        $display("FAIL bp_hold m=%0d: got pv=%b d=%h pr=%b expected pv=0010 d=11 pr=0",
                 m, pop_valid[m], pop_data[m][1], push_ready[m]);
      else passed++;
    end
    @(negedge clk);
    pop_ready[m] = 4'hF;
    #1;
    checks++;
    if (pop_valid[m] !== 4'b0010) $display("FAIL bp_release m=%0d: got %b expected 0010", m, pop_valid[m]);
    else passed++;
    @(negedge clk);
    push_valid[m] = 1'b0;
    #1;
    checks++;
    if (pop_valid[m] !== 4'b1000 || pop_data[m][3] !== 8'h22)
      $display("FAIL bp_second m=%0d: got pv=%b d=%h expected pv=1000 d=22", m, pop_valid[m], pop_data[m][3]);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if (pop_valid[m] !== 4'b0) $display("FAIL bp_drain m=%0d: got %b expected 0000", m, pop_valid[m]);
    else passed++;
  endtask

  task automatic test_hol(input int m);
    logic acc;
    logic pend;
    q.delete();
    step(m, 1'b1, 8'h01, 2'd0, 4'b1000, acc);
    pend = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(m, pend, 8'h02, 2'd3, 4'b1000, acc);
      pend = pend & !acc;
      checks++;
      if (pop_valid[m][3] !== 1'b0) $display("FAIL hol_overtake m=%0d: got pv=%b expected 0001", m, pop_valid[m]);
      else passed++;
    end
    for (int i = 0; i < 6 && (pend || q.size() != 0); i++) begin
      step(m, pend, 8'h02, 2'd3, 4'hF, acc);
      pend = pend & !acc;
    end
    step(m, 1'b0, 8'h00, 2'd0, 4'hF, acc);
    checks++;
    if (pend || q.size() != 0) $display("FAIL hol_drain m=%0d: got %0d left expected 0", m, q.size());
    else passed++;
  endtask

  task automatic test_async_reset(input int m);
    logic acc;
    @(negedge clk);
    push_valid[m] = 1'b1; push_data[m] = 8'h33; push_select[m] = 2'd0; pop_ready[m] = 4'h0;
    @(negedge clk);
    push_data[m] = 8'h44; push_select[m] = 2'd2;
    @(negedge clk);
    push_valid[m] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pop_valid[m] !== 4'b0 || push_ready[m] !== 1'b0)
      $display("FAIL async_reset m=%0d: got pv=%b pr=%b expected pv=0000 pr=0", m, pop_valid[m], push_ready[m]);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pop_ready[m] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (pop_valid[m] !== 4'b0) $display("FAIL async_stale m=%0d: got %b expected 0000", m, pop_valid[m]);
      else passed++;
    end
    q.delete();
    step(m, 1'b1, 8'h55, 2'd1, 4'hF, acc);
    step(m, 1'b0, 8'h00, 2'd0, 4'hF, acc);
    step(m, 1'b0, 8'h00, 2'd0, 4'hF, acc);
  endtask

  task automatic test_random(input int m, input int n);
    logic pv, acc, pend;
    logic [7:0] d;
    logic [1:0] s;
    q.delete();
    pend = 1'b0; pv = 1'b0; d = 8'h0; s = 2'd0;
    for (int i = 0; i < n; i++) begin
      if (!pend) begin
        pv = ($urandom_range(0, 9) < 7);
        d = 8'($urandom);
        s = 2'($urandom);
      end
      step(m, pv, d, s, 4'($urandom), acc);
      pend = pv & !acc;
    end
    for (int i = 0; i < 12 && (pend || q.size() != 0); i++) begin
      step(m, pend, d, s, 4'hF, acc);
      pend = pend & !acc;
    end
    checks++;
    if (pend || q.size() != 0) $display("FAIL random_drain m=%0d: got %0d left expected 0", m, q.size());
    else passed++;
    step(m, 1'b0, 8'h00, 2'd0, 4'hF, acc);
  endtask

  task automatic test_back_to_back();
    logic acc;
    q.delete();
    pops = 0;
    for (int i = 0; i < 100; i++) step(1, 1'b1, 8'($urandom), 2'(i), 4'hF, acc);
    step(1, 1'b0, 8'h00, 2'd0, 4'hF, acc);
    checks++;
    if (pops != 100 || q.size() != 0) $display("FAIL throughput: got %0d pops in 101 cycles expected 100", pops);
    else passed++;
    step(1, 1'b0, 8'h00, 2'd0, 4'hF, acc);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      push_valid[m] = 1'b0; push_data[m] = 8'h0; push_select[m] = 2'd0; pop_ready[m] = 4'h0;
    end
    test_reset();
    for (int m = 0; m < 2; m++) begin
      test_routing(m);
      test_backpressure(m);
      test_hol(m);
      test_async_reset(m);
      test_random(m, 300);
    end
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
